bcd_updown_counter_n: RTL and testbench
=======================================

Name: bcd_updown_counter_n

Overview:
- Parametrised multi-digit synchronous up/down BCD counter. It is the successor to the single-digit JK-based up/down BCD counter.
- Adds digit count, wrap or saturate mode, count enable, parallel load with BCD validity check, terminal-count output and an overflow flag.
- Used as a general decimal event/time counter. It can be cascaded through tc.

Parameters:
- DIGITS, 2, number of BCD digits; legal range 1..8; count width = 4*DIGITS.
- WRAP, 1, 1 = wrap at the terminal value (all-9s up -> all-0s; all-0s down -> all-9s); 0 = saturate (hold at the terminal value).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- en  input  1  count enable; counts one step per clk when high.
- x  input  1  direction; 1 = up, 0 = down (sampled every cycle, no latency).
- load  input  1  synchronous parallel load request.
- din  input  4*DIGITS  load value; nibble i = decimal digit i, nibble 0 = least significant digit.
- count  output  4*DIGITS  registered BCD count, same digit ordering as din.
- tc  output  1  combinational terminal count: en & ((x & count==all-9s) | (~x & count==all-0s)).
- ovf  output  1  registered one-cycle pulse: a step was attempted at the terminal value.
- load_err  output  1  registered one-cycle pulse: a load was rejected for an invalid nibble.

Behaviour:
- All state changes occur on the rising edge of clk. The single clock and the synchronous active-high rst are fixed.
- Priority per edge: rst > load > en > hold.
- rst=1: count=0, ovf=0, load_err=0 on that edge. Reset mid-count discards the current state; counting resumes from 0 on the first edge with rst=0.
- load=1, all din nibbles <=9:
  - count<=din.
  - ovf<=0, load_err<=0.
  - en is ignored that cycle.
- load=1, any din nibble >9:
  - count unchanged.
  - load_err<=1 for exactly one cycle.
  - ovf<=0.
  - en is ignored that cycle (no count step).
- load=0, en=1, x=1 (up):
  - Digit 0 always steps.
  - Digit i>0 steps only when digits 0..i-1 are all 9.
  - A stepping digit goes 0..8 -> +1; 9 -> 0.
- load=0, en=1, x=0 (down):
  - Digit 0 always steps.
  - Digit i>0 steps only when digits 0..i-1 are all 0.
  - A stepping digit goes 1..9 -> -1; 0 -> 9.
- Terminal step (tc=1, load=0, rst=0):
  - ovf<=1 for one cycle.
  - WRAP=1: count takes the wrapped value.
  - WRAP=0: count holds.
- All other non-reset edges: ovf<=0, load_err<=0.
- load=0, en=0: count holds; ovf and load_err clear to 0.
- Latency:
  - count reflects a step or load one edge after sampling.
  - ovf and load_err assert on that same edge.
  - tc has zero latency and is combinational from count, en and x.
- Direction change takes effect on the very next enabled edge. There is no internal direction state.
- count never holds a non-BCD nibble: it is reachable only via reset, a valid load or a step.

Test Plan:
- DIGITS=2, WRAP=1: rst 1 cycle, then en=1, x=1 for 12 edges -> count 00,01..09,10,11,12. Carry 09->10 occurs on the 10th edge; ovf stays 0.
- DIGITS=2, WRAP=1: load din=0x98, then en=1, x=1 -> 98, 99 (tc=1), 00 with ovf=1 for exactly one cycle, then 01 with ovf=0. Repeat with x=0 from 01: 00 (tc=1), 99 with ovf=1.
- DIGITS=2, WRAP=0: load 0x99, en=1, x=1 for 3 edges -> count stays 99 and ovf=1 on each edge. Then x=0 -> 98, ovf=0. Load 0x00, x=0 -> holds 00 with ovf=1.
- DIGITS=3: load 0x1A5 -> count unchanged and load_err=1 for one cycle. Load 0x905 with en=1, x=1 in the same cycle -> count=905 (no step); next edge 906.
- DIGITS=2: count up to 0x37, then x=0 for 3 edges -> 36, 35, 34. Assert rst mid-count with en=1 -> count=00 on that edge; rst wins over a simultaneous load=1, din=0x55.
- DIGITS=4, WRAP=1, down from reset: first edge -> 9999 with ovf=1; next edge -> 9998. Load 0x1000 then one down step -> 0999, verifying the 4-digit borrow chain.

Source files
------------

// File: rtl/bcd_updown_counter_n.sv
// bcd_updown_counter_n
// Multi-digit synchronous up/down BCD counter with wrap or saturate at the
// terminal value, count enable, validated parallel load, combinational
// terminal count for cascading, and one-cycle overflow / load-error pulses.
//
// Per-edge priority: rst > load > en > hold.
//
// Each digit steps only when every lower digit sits at its roll-over value:
// 9 when counting up, 0 when counting down. The ripple is modelled as
// explicit enable chains so the decision for every digit is visible at once.
module bcd_updown_counter_n #(
  parameter int DIGITS = 2,
  parameter bit WRAP   = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  x,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   din,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  ovf,
  output logic                  load_err
);

  localparam int W = 4 * DIGITS;

  generate
    if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
      $error("bcd_updown_counter_n: DIGITS must be in 1..8");
    end
  endgenerate

  logic [W-1:0]      r_count;
  logic              r_ovf;
  logic              r_load_err;

  logic [DIGITS-1:0] w_is9;
  logic [DIGITS-1:0] w_is0;
  logic [DIGITS-1:0] w_nib_ok;
  logic [DIGITS:0]   w_up_chain;
  logic [DIGITS:0]   w_dn_chain;
  logic [W-1:0]      w_up_val;
  logic [W-1:0]      w_dn_val;
  logic [W-1:0]      w_step_val;
  logic              w_all9;
  logic              w_all0;
  logic              w_din_ok;
  logic              w_term;

  // Digit 0 always steps; higher digits inherit the enable from below.
  assign w_up_chain[0] = 1'b1;
  assign w_dn_chain[0] = 1'b1;

  generate
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
      logic [3:0] w_dig;
      assign w_dig       = r_count[4*g +: 4];
      assign w_is9[g]    = (w_dig == 4'd9);
      assign w_is0[g]    = (w_dig == 4'd0);
      assign w_nib_ok[g] = (din[4*g +: 4] <= 4'd9);

      assign w_up_chain[g+1] = w_up_chain[g] & w_is9[g];
      assign w_dn_chain[g+1] = w_dn_chain[g] & w_is0[g];

      assign w_up_val[4*g +: 4] = !w_up_chain[g] ? w_dig :
                                  (w_is9[g] ? 4'd0 : w_dig + 4'd1);
      assign w_dn_val[4*g +: 4] = !w_dn_chain[g] ? w_dig :
                                  (w_is0[g] ? 4'd9 : w_dig - 4'd1);
    end
  endgenerate

  // A full chain means every digit is at its roll-over value: the terminal count.
  assign w_all9     = w_up_chain[DIGITS];
  assign w_all0     = w_dn_chain[DIGITS];
  assign w_din_ok   = &w_nib_ok;
  assign w_step_val = x ? w_up_val : w_dn_val;
  assign w_term     = x ? w_all9 : w_all0;

  // Count register with reset, validated load, enabled step and hold.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count    <= '0;
      r_ovf      <= 1'b0;
      r_load_err <= 1'b0;
    end else if (load) begin
      r_ovf <= 1'b0;
      if (w_din_ok) begin
        r_count    <= din;
        r_load_err <= 1'b0;
      end else begin
        r_load_err <= 1'b1;
      end
    end else if (en) begin
      r_load_err <= 1'b0;
      r_ovf      <= w_term;
      // Stepping from the terminal value yields the wrapped value naturally;
      // saturating mode simply refuses that step.
      if (!w_term || WRAP) begin
        r_count <= w_step_val;
      end
    end else begin
      r_ovf      <= 1'b0;
      r_load_err <= 1'b0;
    end
  end

  assign count    = r_count;
  assign ovf      = r_ovf;
  assign load_err = r_load_err;
  assign tc       = en & w_term;

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Bench for bcd_updown_counter_n: four configurations share one stimulus
// stream and are compared every cycle against an integer-arithmetic model.
module tb_bcd_updown_counter_n;

  logic        clk = 1'b0;
  logic        rst, en, x, load;
  logic [31:0] din;

  always #5 clk = ~clk;

  logic [7:0]  cnt_a, cnt_b;
  logic [11:0] cnt_c;
  logic [15:0] cnt_d;
  logic        tc_a, tc_b, tc_c, tc_d;
  logic        ovf_a, ovf_b, ovf_c, ovf_d;
  logic        err_a, err_b, err_c, err_d;

  bcd_updown_counter_n #(.DIGITS(2), .WRAP(1'b1)) u_a (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .din(din[7:0]),
    .count(cnt_a), .tc(tc_a), .ovf(ovf_a), .load_err(err_a));
  bcd_updown_counter_n #(.DIGITS(2), .WRAP(1'b0)) u_b (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .din(din[7:0]),
    .count(cnt_b), .tc(tc_b), .ovf(ovf_b), .load_err(err_b));
  bcd_updown_counter_n #(.DIGITS(3), .WRAP(1'b1)) u_c (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .din(din[11:0]),
    .count(cnt_c), .tc(tc_c), .ovf(ovf_c), .load_err(err_c));
  bcd_updown_counter_n #(.DIGITS(4), .WRAP(1'b1)) u_d (
    .clk(clk), .rst(rst), .en(en), .x(x), .load(load), .din(din[15:0]),
    .count(cnt_d), .tc(tc_d), .ovf(ovf_d), .load_err(err_d));

  logic [31:0] g_cnt [4];
  logic        g_tc  [4];
  logic        g_ovf [4];
  logic        g_err [4];
  assign g_cnt[0] = {24'd0, cnt_a};
  assign g_cnt[1] = {24'd0, cnt_b};
  assign g_cnt[2] = {20'd0, cnt_c};
  assign g_cnt[3] = {16'd0, cnt_d};
  assign g_tc[0] = tc_a;   assign g_tc[1] = tc_b;   assign g_tc[2] = tc_c;   assign g_tc[3] = tc_d;
  assign g_ovf[0] = ovf_a; assign g_ovf[1] = ovf_b; assign g_ovf[2] = ovf_c; assign g_ovf[3] = ovf_d;
  assign g_err[0] = err_a; assign g_err[1] = err_b; assign g_err[2] = err_c; assign g_err[3] = err_d;

  int nd [4]   = '{2, 2, 3, 4};
  bit wrp [4]  = '{1'b1, 1'b0, 1'b1, 1'b1};
  int m_val [4];
  bit m_ovf [4];
  bit m_err [4];
  bit m_known = 1'b0;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
  endtask

  function automatic int pow10(input int d);
    int p = 1;
    for (int k = 0; k < d; k++) p = p * 10;
    return p;
  endfunction

  function automatic logic [31:0] int2bcd(input int v, input int d);
    logic [31:0] r = '0;
    int t = v;
    for (int k = 0; k < d; k++) begin
      r[4*k +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic bit din_valid(input logic [31:0] v, input int d);
    for (int k = 0; k < d; k++)
      if (v[4*k +: 4] > 4'd9) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int bcd2int(input logic [31:0] v, input int d);
    int r = 0;
    for (int k = d - 1; k >= 0; k--) r = r * 10 + int'(v[4*k +: 4]);
    return r;
  endfunction

  task automatic model_edge(input logic r, input logic l, input logic e,
                            input logic xx, input logic [31:0] d);
    for (int i = 0; i < 4; i++) begin
      int mx;
      bit term;
      mx = pow10(nd[i]) - 1;
      if (r) begin
        m_val[i] = 0; m_ovf[i] = 0; m_err[i] = 0;
      end else if (l) begin
        m_ovf[i] = 0;
        if (din_valid(d, nd[i])) begin
          m_val[i] = bcd2int(d, nd[i]);
          m_err[i] = 0;
        end else begin
          m_err[i] = 1;
        end
      end else if (e) begin
        term = xx ? (m_val[i] == mx) : (m_val[i] == 0);
        m_ovf[i] = term;
        m_err[i] = 0;
        if (term) begin
          if (wrp[i]) m_val[i] = xx ? 0 : mx;
        end else begin
          m_val[i] = xx ? m_val[i] + 1 : m_val[i] - 1;
        end
      end else begin
        m_ovf[i] = 0; m_err[i] = 0;
      end
    end
    if (r) m_known = 1'b1;
  endtask

  // One clock: drive inputs, check tc before the edge, then state after it.
  task automatic cyc(input logic r, input logic l, input logic e,
                     input logic xx, input logic [31:0] d);
    rst = r; load = l; en = e; x = xx; din = d;
    #1;
    if (m_known) begin
      for (int i = 0; i < 4; i++) begin
        bit exp_tc;
        exp_tc = e && (xx ? (m_val[i] == pow10(nd[i]) - 1) : (m_val[i] == 0));
        chk($sformatf("tc[%0d]", i), {31'd0, g_tc[i]}, {31'd0, exp_tc});
      end
    end
    @(posedge clk);
    model_edge(r, l, e, xx, d);
    #1;
    if (m_known) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("count[%0d]", i), g_cnt[i], int2bcd(m_val[i], nd[i]));
        chk($sformatf("ovf[%0d]", i), {31'd0, g_ovf[i]}, {31'd0, m_ovf[i]});
        chk($sformatf("load_err[%0d]", i), {31'd0, g_err[i]}, {31'd0, m_err[i]});
      end
    end
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; en = 1'b0; x = 1'b0; din = '0;
    @(posedge clk); #1;

    // Reset, then twelve up steps: 00 .. 12, carry on the tenth.
    cyc(1, 0, 0, 0, 32'h0);
    chk("reset_cnt", g_cnt[0], 32'h00);
    for (int k = 0; k < 12; k++) cyc(0, 0, 1, 1, 32'h0);
    chk("up12", g_cnt[0], 32'h12);

    // Wrap up through 99 -> 00, then down through 00 -> 99.
    cyc(0, 1, 1, 1, 32'h98);
    chk("load98", g_cnt[0], 32'h98);
    cyc(0, 0, 1, 1, 32'h0);
    cyc(0, 0, 1, 1, 32'h0);
    chk("wrap_up", g_cnt[0], 32'h00);
    chk("wrap_up_ovf", {31'd0, ovf_a}, 32'd1);
    cyc(0, 0, 1, 1, 32'h0);
    cyc(0, 0, 1, 0, 32'h0);
    cyc(0, 0, 1, 0, 32'h0);
    chk("wrap_dn", g_cnt[0], 32'h99);

    // Saturation: hold at 99 going up, at 00 going down.
    cyc(0, 1, 0, 0, 32'h99);
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 1, 32'h0);
    chk("sat_up", g_cnt[1], 32'h99);
    chk("sat_up_ovf", {31'd0, ovf_b}, 32'd1);
    cyc(0, 0, 1, 0, 32'h0);
    cyc(0, 1, 0, 0, 32'h00);
    cyc(0, 0, 1, 0, 32'h0);
    chk("sat_dn", g_cnt[1], 32'h00);

    // Rejected load, then load with en high (no step that cycle).
    cyc(0, 1, 0, 0, 32'h1A5);
    chk("bad_load_err", {31'd0, err_c}, 32'd1);
    cyc(0, 1, 1, 1, 32'h905);
    chk("load905", g_cnt[2], 32'h905);
    cyc(0, 0, 1, 1, 32'h0);
    chk("step906", g_cnt[2], 32'h906);

    // Up to 37, down three, then reset beats a simultaneous load.
    cyc(0, 1, 0, 0, 32'h30);
    for (int k = 0; k < 7; k++) cyc(0, 0, 1, 1, 32'h0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 1, 0, 32'h0);
    chk("dn34", g_cnt[0], 32'h34);
    cyc(1, 1, 1, 1, 32'h55);
    chk("rst_beats_load", g_cnt[0], 32'h00);

    // Four-digit down from reset and borrow chain.
    cyc(0, 0, 1, 0, 32'h0);
    chk("d4_wrap", g_cnt[3], 32'h9999);
    cyc(0, 0, 1, 0, 32'h0);
    cyc(0, 1, 0, 0, 32'h1000);
    cyc(0, 0, 1, 0, 32'h0);
    chk("d4_borrow", g_cnt[3], 32'h0999);

    // Random traffic, biased toward valid digits so loads mostly succeed.
    for (int k = 0; k < 600; k++) begin
      logic [31:0] d;
      for (int n = 0; n < 8; n++)
        d[4*n +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                  : 4'($urandom_range(0, 9));
      if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) == 0) ? 32'h99999999 : 32'h0;
      cyc(($urandom_range(0, 40) == 0), ($urandom_range(0, 7) == 0),
          ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), d);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
